// File: rtl/dmem_port_arbiter_pkg.sv
// Shared definitions for the data-memory port arbiter and its clients
// (core LSU on port 0, program/debug loader on port 1).
package dmem_port_arbiter_pkg;

   localparam int DMEM_N    = 32;  // data / byte-address width
   localparam int DMEM_AW   = 10;  // word-index width (1024 words)
   localparam int PORT_CORE = 0;
   localparam int PORT_LOAD = 1;

   typedef struct packed {
      logic              valid;
      logic              we;
      logic [DMEM_N-1:0] addr;
      logic [DMEM_N-1:0] wdata;
   } dmem_req_t;

   typedef struct packed {
      logic              valid;
      logic              err;
      logic [DMEM_N-1:0] rdata;
   } dmem_rsp_t;

   // Misaligned or beyond the implemented word range.
   function automatic logic dmem_addr_err(input logic [DMEM_N-1:0] addr);
      return (addr[1:0] != 2'b00) || (addr[DMEM_N-1:DMEM_AW+2] != '0);
   endfunction

endpackage

// File: rtl/dmem_port_arbiter_rr_arb2.sv
// Two-way round-robin grant.
//   req  : request per port
//   gnt  : one-hot (or zero) grant, combinational from req and last_grant
// last_grant resets to 1 so port 0 wins the first contention.
module rr_arb2
   import dmem_port_arbiter_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic [1:0] req,
   output logic [1:0] gnt
);

   logic last_grant;

   always_comb begin
      gnt = 2'b00;
      if (req[PORT_CORE] && (!req[PORT_LOAD] || last_grant))
         gnt[PORT_CORE] = 1'b1;
      else if (req[PORT_LOAD])
         gnt[PORT_LOAD] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         last_grant <= 1'b1;
      else if (|gnt)
         last_grant <= gnt[PORT_LOAD];
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port data memory between the core LSU (port 0) and the
// loader (port 1). One access per cycle; byte address -> word index; bad
// addresses are rejected without a memory write. Responses are registered
// and appear one cycle after the transfer.
//   req*_valid/we/addr/wdata, req*_ready : request handshake per port
//   rsp*_valid/rdata/err                 : registered response per port
//   mem_we/addr/wdata, mem_rdata         : memory side (rdata combinational)
module dmem_port_arbiter
   import dmem_port_arbiter_pkg::*;
#(
   parameter int N  = DMEM_N,
   parameter int AW = DMEM_AW
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         req0_valid,
   input  logic         req0_we,
   input  logic [N-1:0] req0_addr,
   input  logic [N-1:0] req0_wdata,
   output logic         req0_ready,
   input  logic         req1_valid,
   input  logic         req1_we,
   input  logic [N-1:0] req1_addr,
   input  logic [N-1:0] req1_wdata,
   output logic         req1_ready,
   output logic         rsp0_valid,
   output logic [N-1:0] rsp0_rdata,
   output logic         rsp0_err,
   output logic         rsp1_valid,
   output logic [N-1:0] rsp1_rdata,
   output logic         rsp1_err,
   output logic         mem_we,
   output logic [N-1:0] mem_addr,
   output logic [N-1:0] mem_wdata,
   input  logic [N-1:0] mem_rdata
);

   logic [1:0]        gnt;
   logic              any, sel, g_we, err;
   logic [N-1:0]      g_addr, g_wdata, rd_nxt;

   rr_arb2 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   ({req1_valid, req0_valid}),
      .gnt   (gnt)
   );

   assign req0_ready = gnt[PORT_CORE];
   assign req1_ready = gnt[PORT_LOAD];
   assign any        = |gnt;
   assign sel        = gnt[PORT_LOAD];

   assign g_we    = sel ? req1_we    : req0_we;
   assign g_addr  = sel ? req1_addr  : req0_addr;
   assign g_wdata = sel ? req1_wdata : req0_wdata;

   assign err = (g_addr[1:0] != 2'b00) || (g_addr[N-1:AW+2] != '0);

   assign mem_addr  = any ? {{(N-AW){1'b0}}, g_addr[AW+1:2]} : '0;
   assign mem_wdata = any ? g_wdata : '0;
   // rst_n gates the strobe so a request held through reset cannot write.
   assign mem_we    = any & g_we & ~err & rst_n;

   assign rd_nxt = (g_we || err) ? '0 : mem_rdata;

   // rdata/err only load on that port's transfer; otherwise they hold.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp0_valid <= 1'b0;
         rsp0_err   <= 1'b0;
         rsp0_rdata <= '0;
         rsp1_valid <= 1'b0;
         rsp1_err   <= 1'b0;
         rsp1_rdata <= '0;
      end else begin
         rsp0_valid <= gnt[PORT_CORE];
         rsp1_valid <= gnt[PORT_LOAD];
         if (gnt[PORT_CORE]) begin
            rsp0_err   <= err;
            rsp0_rdata <= rd_nxt;
         end
         if (gnt[PORT_LOAD]) begin
            rsp1_err   <= err;
            rsp1_rdata <= rd_nxt;
         end
      end
   end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req0_valid = 0, req0_we = 0, req1_valid = 0, req1_we = 0;
   logic [31:0] req0_addr = 0, req0_wdata = 0, req1_addr = 0, req1_wdata = 0;
   logic        req0_ready, req1_ready;
   logic        rsp0_valid, rsp0_err, rsp1_valid, rsp1_err;
   logic [31:0] rsp0_rdata, rsp1_rdata;
   logic        mem_we;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   always #5 clk = ~clk;

   dmem_port_arbiter dut (
      .clk(clk), .rst_n(rst_n),
      .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr),
      .req0_wdata(req0_wdata), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr),
      .req1_wdata(req1_wdata), .req1_ready(req1_ready),
      .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata), .rsp0_err(rsp0_err),
      .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata), .rsp1_err(rsp1_err),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata)
   );

   // Data memory instance seen by the DUT.
   logic [31:0] tb_mem [0:1023] = '{default: 32'h0};
   assign mem_rdata = tb_mem[mem_addr[9:0]];
   always @(posedge clk) if (mem_we) tb_mem[mem_addr[9:0]] <= mem_wdata;

   int total = 0, bad = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] ref_mem [0:1023] = '{default: 32'h0};
   int          m_last = 1;
   bit          e_v [2];
   bit          e_err [2];
   logic [31:0] e_rd [2];
   bit          acc0, acc1;

   always @(negedge clk) begin
      int g;
      bit er;
      bit v [2];
      bit w [2];
      logic [31:0] a [2];
      logic [31:0] d [2];
      bit rv [2];
      bit re [2];
      logic [31:0] rr [2];
      v[0] = req0_valid; w[0] = req0_we; a[0] = req0_addr; d[0] = req0_wdata;
      v[1] = req1_valid; w[1] = req1_we; a[1] = req1_addr; d[1] = req1_wdata;
      rv[0] = rsp0_valid; re[0] = rsp0_err; rr[0] = rsp0_rdata;
      rv[1] = rsp1_valid; re[1] = rsp1_err; rr[1] = rsp1_rdata;
      if (!rst_n) m_last = 1;
      g = -1;
      if (v[0] && v[1]) g = (m_last == 0) ? 1 : 0;
      else if (v[0])    g = 0;
      else if (v[1])    g = 1;
      chk("ready0", req0_ready, (g == 0));
      chk("ready1", req1_ready, (g == 1));
      if (!rst_n) begin
         chk("rst_mem_we", mem_we, 0);
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rst_rsp%0d_valid", p), rv[p], 0);
            chk($sformatf("rst_rsp%0d_err", p), re[p], 0);
            chk($sformatf("rst_rsp%0d_rdata", p), rr[p], 0);
            e_v[p] = 0; e_err[p] = 0; e_rd[p] = 0;
         end
         acc0 = 0; acc1 = 0;
      end else begin
         er = 0;
         if (g >= 0) er = (a[g] % 4 != 0) || (a[g] >= 32'd4096);
         if (g >= 0) begin
            chk("mem_we", mem_we, (w[g] && !er));
            chk("mem_addr", mem_addr, (a[g] >> 2) & 32'h3FF);
            chk("mem_wdata", mem_wdata, d[g]);
         end else begin
            chk("idle_mem_we", mem_we, 0);
            chk("idle_mem_addr", mem_addr, 0);
            chk("idle_mem_wdata", mem_wdata, 0);
         end
         for (int p = 0; p < 2; p++) begin
            chk($sformatf("rsp%0d_valid", p), rv[p], e_v[p]);
            chk($sformatf("rsp%0d_err", p), re[p], e_err[p]);
            chk($sformatf("rsp%0d_rdata", p), rr[p], e_rd[p]);
         end
         for (int p = 0; p < 2; p++) begin
            e_v[p] = (g == p);
            if (g == p) begin
               e_err[p] = er;
               e_rd[p]  = (w[p] || er) ? 32'h0 : ref_mem[a[p] >> 2];
            end
         end
         if (g >= 0 && w[g] && !er) ref_mem[a[g] >> 2] = d[g];
         if (g >= 0) m_last = g;
         acc0 = (g == 0);
         acc1 = (g == 1);
      end
   end

   // ---------------- stimulus ----------------
   task automatic drv(input int p, input bit v, input bit we,
                      input logic [31:0] a, input logic [31:0] d);
      if (p == 0) begin
         req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
      end else begin
         req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
      end
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0);
      drv(1, 0, 0, 0, 0);
   endtask

   function automatic logic [31:0] rnd_addr();
      int r;
      r = $urandom % 16;
      if (r == 0)      return (($urandom % 64) << 2) | ($urandom_range(1, 3));
      else if (r == 1) return ($urandom_range(1, 1000) << 12) | (($urandom % 1024) << 2);
      else if (r == 2) return ($urandom % 1024) << 2;
      else             return ($urandom % 16) << 2;
   endfunction

   int c0, c1;

   initial begin
      idle();
      repeat (2) @(negedge clk);
      chk("t0_rsp0_valid", rsp0_valid, 0);
      chk("t0_rsp1_rdata", rsp1_rdata, 0);
      #2 rst_n = 1'b1;

      // write then read back
      @(posedge clk); #1 drv(0, 1, 1, 32'h10, 32'hDEADBEEF);
      @(negedge clk);
      chk("t1_mem_we", mem_we, 1);
      chk("t1_mem_addr", mem_addr, 4);
      @(posedge clk); #1 drv(0, 1, 0, 32'h10, 0);
      @(negedge clk);
      chk("t1_wr_rsp_valid", rsp0_valid, 1);
      chk("t1_wr_rsp_err", rsp0_err, 0);
      @(posedge clk); #1 idle();
      @(negedge clk);
      chk("t1_rd_rdata", rsp0_rdata, 32'hDEADBEEF);

      // continuous contention alternates, starting with port 0
      @(posedge clk); #1 drv(1, 1, 0, 32'h10, 0);
      @(negedge clk);
      c0 = 0; c1 = 0;
      for (int i = 0; i < 7; i++) begin
         @(posedge clk);
         #1;
         if (i == 0) begin
            drv(0, 1, 0, 32'h10, 0);
            drv(1, 1, 0, 32'h14, 0);
         end else if (i == 6) idle();
         @(negedge clk);
         if (i < 6)
            chk($sformatf("t2_grant%0d", i), {req1_ready, req0_ready},
                (i % 2 == 0) ? 32'h1 : 32'h2);
         if (i >= 1) begin
            c0 += rsp0_valid;
            c1 += rsp1_valid;
         end
      end
      chk("t2_rsp0_pulses", c0, 3);
      chk("t2_rsp1_pulses", c1, 3);

      // misaligned write from port 1
      @(posedge clk); #1 drv(1, 1, 1, 32'h2, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("t3_mem_we", mem_we, 0);
      @(posedge clk); #1 idle();
      @(negedge clk);
      chk("t3_rsp1_valid", rsp1_valid, 1);
      chk("t3_rsp1_err", rsp1_err, 1);
      chk("t3_word0", tb_mem[0], 0);

      // out-of-range read from port 0
      @(posedge clk); #1 drv(0, 1, 0, 32'h1000, 0);
      @(posedge clk); #1 idle();
      @(negedge clk);
      chk("t4_rsp0_err", rsp0_err, 1);
      chk("t4_rsp0_rdata", rsp0_rdata, 0);

      // last_grant = 0, then write(P1) vs read(P0) to same word
      @(posedge clk); #1 drv(0, 1, 0, 32'h24, 0);
      @(posedge clk); #1;
      drv(0, 1, 0, 32'h20, 0);
      drv(1, 1, 1, 32'h20, 32'h55);
      @(negedge clk);
      chk("t5_ready1", req1_ready, 1);
      chk("t5_ready0", req0_ready, 0);
      @(posedge clk); #1 drv(1, 0, 0, 0, 0);
      @(negedge clk);
      chk("t5_ready0_after", req0_ready, 1);
      @(posedge clk); #1 idle();
      @(negedge clk);
      chk("t5_rdata", rsp0_rdata, 32'h55);

      // reset pulse drops the pending response, re-arms port 0 priority
      @(posedge clk); #1 drv(0, 1, 0, 32'h10, 0);
      @(negedge clk);
      #2 rst_n = 1'b0;
      @(posedge clk); #1 idle();
      @(negedge clk);
      chk("t6_rsp0_dropped", rsp0_valid, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      drv(0, 1, 0, 32'h10, 0);
      drv(1, 1, 0, 32'h14, 0);
      @(negedge clk);
      chk("t6_first_p0", req0_ready, 1);
      chk("t6_first_p1", req1_ready, 0);
      @(posedge clk); #1 idle();

      // randomized traffic; held requests stay stable until accepted
      for (int i = 0; i < 600; i++) begin
         @(posedge clk);
         #1;
         if (!req0_valid || acc0)
            drv(0, ($urandom % 4) != 0, $urandom % 2, rnd_addr(), $urandom);
         if (!req1_valid || acc1)
            drv(1, ($urandom % 4) != 0, $urandom % 2, rnd_addr(), $urandom);
      end
      @(posedge clk); #1 idle();
      repeat (3) @(negedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Two-requester arbiter that shares the single-port 32-bit data memory between the core load/store unit (port 0) and the program/debug loader (port 1). It grants at most one access per cycle and converts byte addresses to word indices. It rejects misaligned or out-of-range accesses without touching memory. Read data and write acknowledgements return as registered responses one cycle after the transfer. It sits between the pipeline MEM stage / loader and the data memory instance.

## Interface
- N, 32, data and address width
- AW, 10, word-index width of the memory (1024 words)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid / req1_valid  in  1  request present
- req0_we / req1_we  in  1  1 = write, 0 = read
- req0_addr / req1_addr  in  N  byte address
- req0_wdata / req1_wdata  in  N  write data
- req0_ready / req1_ready  out  1  request accepted this cycle (transfer = valid & ready)
- rsp0_valid / rsp1_valid  out  1  one-cycle response pulse
- rsp0_rdata / rsp1_rdata  out  N  read data, valid with rsp*_valid
- rsp0_err / rsp1_err  out  1  access rejected, valid with rsp*_valid
- mem_we  out  1  write enable to memory
- mem_addr  out  N  word index to memory, upper N-AW bits zero
- mem_wdata  out  N  write data to memory
- mem_rdata  in  N  combinational read data from memory

## Operation
- Grant is combinational from valids and the registered pointer `last_grant`:
  - only one valid: that port wins;
  - both valid: the port ≠ `last_grant` wins;
  - none valid: no grant.
- reqX_ready = grant to X. The loser's ready is 0; it holds its request, and its inputs must stay stable until accepted.
- `last_grant` updates to the winner on every transfer. With continuous contention the ports strictly alternate. No starvation: worst-case wait is 1 cycle.
- Error check on the granted request: err = (addr[1:0] ≠ 0) or (addr[N-1:AW+2] ≠ 0).
- mem_addr = zero-extended addr[AW+1:2] of the granted port; when idle it is 0.
- mem_wdata = wdata of the granted port; when idle it is 0.
- mem_we = grant & we & ~err. Erroring writes never reach memory.
- On a transfer, at the next posedge:
  - rspX_valid = 1 and rspX_err = err;
  - rspX_rdata = mem_rdata for error-free reads, else 0.
- Writes also produce a response (ack, rdata = 0).
- Responses to the non-granted port: valid = 0, and rdata/err hold their previous values.

## Timing
- Request to memory: 0 cycles (combinational). Response: 1 cycle after the transfer edge. Throughput: 1 access per cycle total.
- Read-after-write, same word, back-to-back cycles: the read returns the new data, because the memory write lands at the transfer edge.
- Simultaneous read (port 0) and write (port 1) to the same address: the arbiter serializes them. The loser observes the winner's effect.
- Reset state (rst_n low, asynchronous): `last_grant` = 1, so port 0 wins the first contention. All rsp* outputs are 0.
- ready and mem_* remain combinational functions of the inputs during reset, but mem_we is forced to 0 while rst_n is low.
- Reset mid-operation: a response pending for the next edge is dropped (rsp*_valid = 0 after reset). Requesters must reissue.

## Structure
- Shared package:
  - port index constants PORT_CORE = 0, PORT_LOAD = 1;
  - DMEM_AW = 10;
  - request/response struct typedefs reused by the loader and LSU.
- One natural sub-module: `rr_arb2`, a two-way round-robin grant with its `last_grant` register. Address check, muxing and response registers stay in the top.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to 0x10 → mem_we = 1, mem_addr = 4; next cycle rsp0_valid = 1, rsp0_err = 0. Then a port 0 read of 0x10 → rsp0_rdata = 0xDEADBEEF.
- Both ports read continuously for 6 cycles → grants P0, P1, P0, P1, P0, P1; each rsp*_valid pulses exactly 3 times.
- Port 1 writes to 0x2 (misaligned) → mem_we = 0, rsp1_err = 1; memory word 0 is unchanged.
- Port 0 reads 0x1000 (out of range, AW = 10) → rsp0_err = 1, rsp0_rdata = 0.
- Same cycle: port 1 writes 0x55 to 0x20 and port 0 reads 0x20, with last_grant = 0 → port 1 wins. The next cycle's port 0 read returns 0x55.
- Port 0 read transfers, then rst_n pulses low before the edge → rsp0_valid = 0 after the edge. After release, the first contention grants port 0.
